fetch_decode: RTL and testbench

- Instruction-side datapath stage sitting beside the control FSM.
- Holds the program counter (PC) and the instruction register (IR).
- Muxes the RAM address between the PC and the datapath C register.
- Decodes the IR into the opcode, op, shift, register-number and immediate fields that the control FSM and the register file consume.
- All load strobes (loadpc, loadir, msel, mwrite, nsel) come from the control FSM; the block never sequences itself.

---
 rtl/fetch_decode_pkg.sv | 48 ++++
 rtl/fetch_decode_dff.sv | 17 +
 rtl/fetch_decode_instr_dec.sv | 45 ++++
 rtl/fetch_decode.sv | 97 +++++++++
 tb/tb_fetch_decode.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared constants for the fetch/decode stage: opcode, ALU op, nsel codes and IR field positions.
// The optional halt feature in fetch_decode is enabled with the FETCH_HALT_EN macro.
package fetch_decode_pkg;

  typedef enum logic [2:0] {
    OPC_LDR  = 3'b011,
    OPC_STR  = 3'b100,
    OPC_ALU  = 3'b101,
    OPC_MOV  = 3'b110,
    OPC_HALT = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_CMP = 2'b01,
    OP_AND = 2'b10,
    OP_MVN = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    NSEL_RN  = 2'b00,
    NSEL_RD  = 2'b01,
    NSEL_RM  = 2'b10,
    NSEL_RSV = 2'b11
  } nsel_e;

  // IR field positions (16-bit instruction word)
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 13;
  localparam int OP_MSB    = 12;
  localparam int OP_LSB    = 11;
  localparam int RN_MSB    = 10;
  localparam int RN_LSB    = 8;
  localparam int RD_MSB    = 7;
  localparam int RD_LSB    = 5;
  localparam int SH_MSB    = 4;
  localparam int SH_LSB    = 3;
  localparam int RM_MSB    = 2;
  localparam int RM_LSB    = 0;
  localparam int IMM5_MSB  = 4;
  localparam int IMM8_MSB  = 7;

  // imm5 shares bits with the shift field on memory instructions
  function automatic logic shift_is_imm(input logic [2:0] opc);
    return (opc == OPC_LDR) || (opc == OPC_STR);
  endfunction

endpackage

// File: rtl/fetch_decode_dff.sv
// Parameterised D flip-flop with synchronous active-high reset to a fixed value.
module DFlipFlop #(
  parameter int          W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= RST_VAL;
    else       q <= d;
  end

endmodule

// File: rtl/fetch_decode_instr_dec.sv
// Purely combinational instruction decode: field extraction, shift forcing,
// register-number select and immediate sign extension.
module instr_dec
  import fetch_decode_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] ir,
  input  logic [1:0]        nsel,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        shift,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8
);

  logic [2:0] rn, rd, rm, regsel;

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign op     = ir[OP_MSB:OP_LSB];
  assign rn     = ir[RN_MSB:RN_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rm     = ir[RM_MSB:RM_LSB];

  assign shift = shift_is_imm(opcode) ? 2'b00 : ir[SH_MSB:SH_LSB];

  always_comb begin
    regsel = 3'b000;
    case (nsel)
      NSEL_RN: regsel = rn;
      NSEL_RD: regsel = rd;
      NSEL_RM: regsel = rm;
      default: regsel = 3'b000;
    endcase
  end

  assign readnum  = regsel;
  assign writenum = regsel;

  assign sximm5 = {{(DATA_W-5){ir[IMM5_MSB]}}, ir[IMM5_MSB:0]};
  assign sximm8 = {{(DATA_W-8){ir[IMM8_MSB]}}, ir[IMM8_MSB:0]};

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: PC, IR, fetch counter, RAM address mux and store gating.
// Define FETCH_HALT_EN to make opcode 111 latch a sticky halt that freezes fetch.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loadpc,
  input  logic              loadir,
  input  logic              msel,
  input  logic              mwrite,
  input  logic [1:0]        nsel,
  input  logic [DATA_W-1:0] c_in,
  input  logic [DATA_W-1:0] mdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        shift,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic [CNT_W-1:0]  fetch_count,
  output logic              halted
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              halted_q;
  logic              pc_en, ir_en;

`ifdef FETCH_HALT_EN
  logic halted_d;
  assign halted_d = halted_q | (ir_en && (mdata[OPC_MSB:OPC_LSB] == OPC_HALT));

  DFlipFlop #(.W(1), .RST_VAL(1'b0)) u_halt_ff (
    .clk(clk), .reset(reset), .d(halted_d), .q(halted_q)
  );
`else
  assign halted_q = 1'b0;
`endif

  assign pc_en = loadpc & ~halted_q;
  assign ir_en = loadir & ~halted_q;

  // First PC strobe after reset only disarms first_fetch so word 0 is fetched.
  assign pc_d    = !pc_en ? pc_q : (first_q ? pc_q : pc_q + 1'b1);
  assign first_d = pc_en ? 1'b0 : first_q;
  assign ir_d    = ir_en ? mdata : ir_q;
  assign cnt_d   = (ir_en && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

  DFlipFlop #(.W(ADDR_W), .RST_VAL('0)) u_pc_ff (
    .clk(clk), .reset(reset), .d(pc_d), .q(pc_q)
  );

  DFlipFlop #(.W(1), .RST_VAL(1'b1)) u_first_ff (
    .clk(clk), .reset(reset), .d(first_d), .q(first_q)
  );

  DFlipFlop #(.W(DATA_W), .RST_VAL('0)) u_ir_ff (
    .clk(clk), .reset(reset), .d(ir_d), .q(ir_q)
  );

  DFlipFlop #(.W(CNT_W), .RST_VAL('0)) u_cnt_ff (
    .clk(clk), .reset(reset), .d(cnt_d), .q(cnt_q)
  );

  assign mem_addr  = msel ? c_in[ADDR_W-1:0] : pc_q;
  assign mem_write = mwrite & msel & ~halted_q;

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign fetch_count = cnt_q;
  assign halted      = halted_q;

  instr_dec #(.DATA_W(DATA_W)) u_dec (
    .ir       (ir_q),
    .nsel     (nsel),
    .opcode   (opcode),
    .op       (op),
    .shift    (shift),
    .readnum  (readnum),
    .writenum (writenum),
    .sximm5   (sximm5),
    .sximm8   (sximm8)
  );

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: reset, PC sequencing/wrap, decode fields,
// address mux, store gating, counter saturation, reset override and halt.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        reset, loadpc, loadir, msel, mwrite;
  logic [1:0]  nsel;
  logic [15:0] c_in, mdata;
  logic [7:0]  mem_addr, pc;
  logic        mem_write, halted;
  logic [15:0] ir, sximm5, sximm8, fetch_count;
  logic [2:0]  opcode, readnum, writenum;
  logic [1:0]  op, shift;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_decode dut (
    .clk(clk), .reset(reset), .loadpc(loadpc), .loadir(loadir), .msel(msel),
    .mwrite(mwrite), .nsel(nsel), .c_in(c_in), .mdata(mdata),
    .mem_addr(mem_addr), .mem_write(mem_write), .pc(pc), .ir(ir),
    .opcode(opcode), .op(op), .shift(shift), .readnum(readnum),
    .writenum(writenum), .sximm5(sximm5), .sximm8(sximm8),
    .fetch_count(fetch_count), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change #1 after the edge, so outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; loadpc = 1'b0; loadir = 1'b0; msel = 1'b0; mwrite = 1'b0;
    nsel = 2'b00; c_in = 16'h0; mdata = 16'h0;
    #1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_cnt", fetch_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr", mem_addr, 0);

    loadpc = 1'b1; tick(); loadpc = 1'b0; #1;
    chk("pc_first", pc, 0);
    chk("addr_first", mem_addr, 0);
    loadpc = 1'b1; tick(); loadpc = 1'b0; #1;
    chk("pc_second", pc, 1);
    chk("addr_second", mem_addr, 1);

    loadir = 1'b1; mdata = 16'hD2A5; tick(); loadir = 1'b0; nsel = 2'b00; #1;
    chk("mov_ir", ir, 16'hD2A5);
    chk("mov_opcode", opcode, 3'b110);
    chk("mov_op", op, 2'b10);
    chk("mov_readnum_rn", readnum, 3'b010);
    chk("mov_sximm8", sximm8, 16'hFFA5);
    chk("mov_sximm5", sximm5, 16'h0005);
    chk("mov_shift", shift, 2'b00);
    chk("mov_cnt", fetch_count, 1);
    chk("pc_hold_on_ir", pc, 1);
    nsel = 2'b01; #1;
    chk("mov_writenum_rd", writenum, 3'b101);
    nsel = 2'b10; #1;
    chk("mov_readnum_rm", readnum, 3'b101);
    nsel = 2'b11; #1;
    chk("nsel_rsv", readnum, 3'b000);

    loadir = 1'b1; mdata = 16'h6B1F; tick(); loadir = 1'b0; nsel = 2'b01; #1;
    chk("ldr_opcode", opcode, 3'b011);
    chk("ldr_shift_forced", shift, 2'b00);
    chk("ldr_sximm5", sximm5, 16'hFFFF);
    chk("ldr_sximm8", sximm8, 16'h001F);
    chk("ldr_writenum", writenum, 3'b000);
    chk("ldr_cnt", fetch_count, 2);

    loadir = 1'b1; mdata = 16'hA018; tick(); loadir = 1'b0; #1;
    chk("alu_shift", shift, 2'b11);
    chk("alu_sximm5", sximm5, 16'hFFF8);
    loadir = 1'b1; mdata = 16'h8018; tick(); loadir = 1'b0; #1;
    chk("str_shift_forced", shift, 2'b00);
    chk("str_cnt", fetch_count, 4);

    // loadpc and loadir together: both act independently
    loadpc = 1'b1; loadir = 1'b1; mdata = 16'h1234; tick(); loadpc = 1'b0; loadir = 1'b0; #1;
    chk("both_pc", pc, 2);
    chk("both_ir", ir, 16'h1234);

    loadpc = 1'b1;
    repeat (253) tick();
    loadpc = 1'b0; #1;
    chk("pc_255", pc, 255);
    loadpc = 1'b1; tick(); loadpc = 1'b0; #1;
    chk("pc_wrap", pc, 0);

    msel = 1'b1; c_in = 16'h1234; mwrite = 1'b1; #1;
    chk("addr_c", mem_addr, 8'h34);
    chk("memw_on", mem_write, 1);
    msel = 1'b0; #1;
    chk("memw_gated", mem_write, 0);
    chk("addr_pc", mem_addr, 0);
    mwrite = 1'b0;

    // 5 loads so far; 65530 more reach all-ones, then one more must stick
    loadir = 1'b1; mdata = 16'h0000;
    repeat (65530) tick();
    loadir = 1'b0; #1;
    chk("cnt_max", fetch_count, 16'hFFFF);
    loadir = 1'b1; tick(); loadir = 1'b0; #1;
    chk("cnt_sat", fetch_count, 16'hFFFF);

    loadpc = 1'b1; tick(); loadpc = 1'b0; #1;
    chk("pc_before_rst", pc, 1);
    reset = 1'b1; loadpc = 1'b1; loadir = 1'b1; mdata = 16'hFFFF;
    tick();
    reset = 1'b0; loadir = 1'b0; loadpc = 1'b0; #1;
    chk("midrst_pc", pc, 0);
    chk("midrst_ir", ir, 0);
    chk("midrst_cnt", fetch_count, 0);
    loadpc = 1'b1; tick(); loadpc = 1'b0; #1;
    chk("rearm_pc", pc, 0);
    loadpc = 1'b1; tick(); loadpc = 1'b0; #1;
    chk("rearm_pc2", pc, 1);

    loadir = 1'b1; mdata = 16'hE000; tick(); loadir = 1'b0; #1;
    chk("halt_ir", ir, 16'hE000);
    chk("halt_opcode", opcode, 3'b111);
    chk("halt_cnt", fetch_count, 1);
`ifdef FETCH_HALT_EN
    chk("halted_set", halted, 1);
    msel = 1'b1; mwrite = 1'b1; #1;
    chk("halt_memw", mem_write, 0);
    msel = 1'b0; mwrite = 1'b0;
    loadpc = 1'b1; loadir = 1'b1; mdata = 16'h1234;
    repeat (3) tick();
    loadpc = 1'b0; loadir = 1'b0; #1;
    chk("halt_pc_frozen", pc, 1);
    chk("halt_ir_frozen", ir, 16'hE000);
    chk("halt_cnt_frozen", fetch_count, 1);
    chk("halt_sticky", halted, 1);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    chk("halt_cleared", halted, 0);
`else
    chk("nohalt_flag", halted, 0);
    loadpc = 1'b1; loadir = 1'b1; mdata = 16'h1234; tick(); loadpc = 1'b0; loadir = 1'b0; #1;
    chk("nohalt_pc", pc, 2);
    chk("nohalt_ir", ir, 16'h1234);
    chk("nohalt_cnt", fetch_count, 2);
    msel = 1'b1; mwrite = 1'b1; #1;
    chk("nohalt_memw", mem_write, 1);
    msel = 1'b0; mwrite = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
